// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Two writeback requesters share the single register-file write port:
// r0 carries ALU results and r1 carries memory loads. Each side uses a
// valid/ready handshake. r1 wins ties, but only for MAX_BURST grants in a
// row while r0 is waiting, so r0 cannot starve.
// Accepted writes go through one registered stage that drives the register
// file directly. Writes to address 0 are accepted but never enabled.
// Optional feature macro: REGFILE_WB_FWD_EN. When it is defined, the
// registered write is bypassed to two read ports. When it is not defined,
// the bypass outputs read as constant zero.

module regfile_wb_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int MAX_BURST = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_valid,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_data,
  output logic          r0_ready,
  input  logic          r1_valid,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_data,
  output logic          r1_ready,
  output logic          regWrite,
  output logic [AW-1:0] writeReg,
  output logic [DW-1:0] writeData,
  output logic          pend_valid,
  output logic [AW-1:0] pend_addr,
  input  logic [AW-1:0] fwd_addr1,
  input  logic [AW-1:0] fwd_addr2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic [CW-1:0] burst_cnt_r;
  logic          r0_grant_s;
  logic          r1_grant_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_data_s;
  logic          regwrite_r;
  logic [AW-1:0] writereg_r;
  logic [DW-1:0] writedata_r;

  // Grant: r1 has priority until its burst budget is spent while r0 waits.
  always_comb begin
    r1_grant_s = r1_valid & (~r0_valid | (burst_cnt_r < MAX_CNT));
    r0_grant_s = r0_valid & ~r1_grant_s;
  end

  assign r0_ready = r0_grant_s;
  assign r1_ready = r1_grant_s;

  // Select the accepted request. Address 0 is taken but never enabled.
  always_comb begin
    sel_we_s   = 1'b0;
    sel_addr_s = writereg_r;
    sel_data_s = writedata_r;
    case ({r1_grant_s, r0_grant_s})
      2'b10: begin
        sel_we_s   = (r1_addr != {AW{1'b0}});
        sel_addr_s = r1_addr;
        sel_data_s = r1_data;
      end
      2'b01: begin
        sel_we_s   = (r0_addr != {AW{1'b0}});
        sel_addr_s = r0_addr;
        sel_data_s = r0_data;
      end
      default: begin
        sel_we_s   = 1'b0;
        sel_addr_s = writereg_r;
        sel_data_s = writedata_r;
      end
    endcase
  end

  // Count consecutive r1 grants taken while r0 waits; any r0 grant or r0 idle clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt_r <= {CW{1'b0}};
    end else if (r0_grant_s || !r0_valid) begin
      burst_cnt_r <= {CW{1'b0}};
    end else if (r1_grant_s && (burst_cnt_r != MAX_CNT)) begin
      burst_cnt_r <= burst_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end

  // Output stage: one write per accept. Address and data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_r  <= 1'b0;
      writereg_r  <= {AW{1'b0}};
      writedata_r <= {DW{1'b0}};
    end else begin
      regwrite_r  <= sel_we_s;
      writereg_r  <= sel_addr_s;
      writedata_r <= sel_data_s;
    end
  end

  assign regWrite   = regwrite_r;
  assign writeReg   = writereg_r;
  assign writeData  = writedata_r;
  assign pend_valid = regwrite_r;
  assign pend_addr  = writereg_r;

`ifdef REGFILE_WB_FWD_EN
  // Bypass the registered write to the read ports. Register 0 never matches.
  always_comb begin
    fwd_hit1  = regwrite_r & (writereg_r == fwd_addr1) & (fwd_addr1 != {AW{1'b0}});
    fwd_hit2  = regwrite_r & (writereg_r == fwd_addr2) & (fwd_addr2 != {AW{1'b0}});
    if (fwd_hit1) begin
      fwd_data1 = writedata_r;
    end else begin
      fwd_data1 = {DW{1'b0}};
    end
    if (fwd_hit2) begin
      fwd_data2 = writedata_r;
    end else begin
      fwd_data2 = {DW{1'b0}};
    end
  end
`else
  // Bypass disabled. The read-address inputs stay on the pin list, but the
  // hit and data outputs are forced to zero.
  always_comb begin
    fwd_hit1  = 1'b0 & (|fwd_addr1);
    fwd_hit2  = 1'b0 & (|fwd_addr2);
    fwd_data1 = {DW{1'b0}};
    fwd_data2 = {DW{1'b0}};
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// Grant expectations come from a hand-derived vector table and from
// fixed burst patterns. Expected writes are queued on accept and compared
// one cycle later on the write port.

module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r1_valid;
  logic [4:0]  r0_addr, r1_addr;
  logic [31:0] r0_data, r1_data;
  logic        r0_ready, r1_ready;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic [4:0]  fwd_addr1, fwd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_WB_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  typedef struct {
    logic        r0v;
    logic [4:0]  r0a;
    logic [31:0] r0d;
    logic        r1v;
    logic [4:0]  r1a;
    logic [31:0] r1d;
    int          g;    // expected grant: 0 none, 1 r0, 2 r1
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         sbq[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  vec_t        tbl[12];

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .pend_valid(pend_valid), .pend_addr(pend_addr),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0v, input logic [4:0] r0a, input logic [31:0] r0d,
                              input logic r1v, input logic [4:0] r1a, input logic [31:0] r1d,
                              input int g);
    vec_t v;
    v.r0v = r0v; v.r0a = r0a; v.r0d = r0d;
    v.r1v = r1v; v.r1a = r1a; v.r1d = r1d;
    v.g   = g;
    return v;
  endfunction

  // One cycle: drive, check grant, queue expected write, check write port next cycle.
  task automatic step(input vec_t v, input string nm);
    wr_t e;
    logic h1;
    r0_valid = v.r0v; r0_addr = v.r0a; r0_data = v.r0d;
    r1_valid = v.r1v; r1_addr = v.r1a; r1_data = v.r1d;
    #1;
    chk({nm, "_r0_ready"}, r0_ready, v.g == 1);
    chk({nm, "_r1_ready"}, r1_ready, v.g == 2);
    if (v.g == 1) begin
      e.we = (v.r0a != 5'd0); e.a = v.r0a; e.d = v.r0d;
      sbq.push_back(e);
    end else if (v.g == 2) begin
      e.we = (v.r1a != 5'd0); e.a = v.r1a; e.d = v.r1d;
      sbq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      m_we = e.we; m_addr = e.a; m_data = e.d;
    end else begin
      m_we = 1'b0;
    end
    fwd_addr1 = m_addr;
    fwd_addr2 = m_addr + 5'd1;
    #1;
    h1 = FWD & m_we & (m_addr != 5'd0);
    chk({nm, "_regWrite"}, regWrite, m_we);
    chk({nm, "_writeReg"}, writeReg, m_addr);
    chk({nm, "_writeData"}, writeData, m_data);
    chk({nm, "_pend_valid"}, pend_valid, m_we);
    chk({nm, "_pend_addr"}, pend_addr, m_addr);
    chk({nm, "_fwd_hit1"}, fwd_hit1, h1);
    chk({nm, "_fwd_data1"}, fwd_data1, h1 ? m_data : 32'd0);
    chk({nm, "_fwd_hit2"}, fwd_hit2, 1'b0);
    chk({nm, "_fwd_data2"}, fwd_data2, 32'd0);
  endtask

  // Both requesters valid every cycle; expect r1,r1,r1,r0 repeating from a cleared counter.
  task automatic burst(input int n, input logic [31:0] base);
    logic [31:0] r0d;
    int g;
    r0d = base;
    for (int i = 0; i < n; i++) begin
      g = ((i % 4) == 3) ? 1 : 2;
      step(mk(1'b1, 5'd10, r0d, 1'b1, 5'(11 + (i % 4)), base + 32'd100 + 32'(i), g),
           $sformatf("burst%0h_%0d", base, i));
      if (g == 1) r0d = r0d + 32'd1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1);
    tbl[1]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,    0);
    tbl[2]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h1234, 2);
    tbl[3]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'h55,   2);
    tbl[4]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4, 32'h22,   2);
    tbl[5]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4, 32'h23,   2);
    tbl[6]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd6, 32'h24,   2);
    tbl[7]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd6, 32'h24,   1);
    tbl[8]  = mk(1'b1, 5'd9,  32'h99,       1'b1, 5'd9, 32'h98,   2);
    tbl[9]  = mk(1'b1, 5'd9,  32'h99,       1'b0, 5'd0, 32'h0,    1);
    tbl[10] = mk(1'b1, 5'd0,  32'h77,       1'b0, 5'd0, 32'h0,    1);
    tbl[11] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd1, 32'hA1,   2);

    reset = 1'b0;
    r0_valid = 1'b0; r0_addr = 5'd0; r0_data = 32'd0;
    r1_valid = 1'b0; r1_addr = 5'd0; r1_data = 32'd0;
    fwd_addr1 = 5'd0; fwd_addr2 = 5'd0;
    m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    #1;
    chk("rst_regWrite", regWrite, 1'b0);
    chk("rst_writeReg", writeReg, 5'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_pend_valid", pend_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));

    burst(8, 32'hC000);

    // Reset mid-stream, two r1 grants into a burst with a write on the port.
    burst(2, 32'hD000);
    r0_valid = 1'b0; r1_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_regWrite", regWrite, 1'b0);
    chk("midrst_writeReg", writeReg, 5'd0);
    chk("midrst_writeData", writeData, 32'd0);
    chk("midrst_pend_valid", pend_valid, 1'b0);
    chk("midrst_pend_addr", pend_addr, 5'd0);
    chk("midrst_fwd_hit1", fwd_hit1, 1'b0);
    sbq.delete();
    m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("postrst_regWrite", regWrite, 1'b0);
    // Burst counter must restart from zero: full r1,r1,r1,r0 pattern again.
    burst(8, 32'hE000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
